// File: rtl/dispatch_ctrl_pkg.sv
// rtl/dispatch_ctrl_pkg.sv - shared widths and FSM encodings for the dispatch stage
package dispatch_ctrl_pkg;

  localparam int DATA_WID   = 32;
  localparam int ADDR_WID   = 32;
  localparam int REG_ID_WID = 5;
  localparam int ROB_ID_WID = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2
  } state_e;

endpackage

// File: rtl/dispatch_ctrl_operand_slot.sv
// rtl/dispatch_ctrl_operand_slot.sv - one source operand: capture from regfile, then resolve on a matching commit
module operand_slot
  import dispatch_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_WID,
  parameter int REG_ID_W = REG_ID_WID,
  parameter int ROB_ID_W = ROB_ID_WID
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                capture_i,
  input  logic                snoop_i,
  input  logic                use_i,
  input  logic [REG_ID_W-1:0] idx_i,
  input  logic                ans_busy_i,
  input  logic [DATA_W-1:0]   ans_data_i,
  input  logic [ROB_ID_W-1:0] ans_tag_i,
  input  logic                commit_i,
  input  logic [ROB_ID_W-1:0] commit_id_i,
  input  logic [DATA_W-1:0]   commit_data_i,
  output logic                busy_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [ROB_ID_W-1:0] tag_o
);

  logic                busy_q, busy_d, busy_base;
  logic [DATA_W-1:0]   data_q, data_d, data_base;
  logic [ROB_ID_W-1:0] tag_q, tag_d, tag_base;

  always_comb begin
    busy_base = busy_q;
    data_base = data_q;
    tag_base  = tag_q;
    // x0 and unused operands are always ready with value zero
    if (capture_i) begin
      if (use_i && (idx_i != '0)) begin
        busy_base = ans_busy_i;
        data_base = ans_data_i;
        tag_base  = ans_tag_i;
      end else begin
        busy_base = 1'b0;
        data_base = '0;
        tag_base  = '0;
      end
    end
    busy_d = busy_base;
    data_d = data_base;
    tag_d  = tag_base;
    if (snoop_i && commit_i && busy_base && (commit_id_i == tag_base)) begin
      busy_d = 1'b0;
      data_d = commit_data_i;
      tag_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
    end else if (en_i) begin
      busy_q <= busy_d;
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  assign busy_o = busy_q;
  assign data_o = data_q;
  assign tag_o  = tag_q;

endmodule

// File: rtl/dispatch_ctrl.sv
// rtl/dispatch_ctrl.sv - dispatch sequencer: accept, regfile read + ROB alloc + rename, hold packet for RS
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_WID,
  parameter int ADDR_W   = ADDR_WID,
  parameter int REG_ID_W = REG_ID_WID,
  parameter int ROB_ID_W = ROB_ID_WID
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_pc,
  input  logic [REG_ID_W-1:0] in_rs1,
  input  logic [REG_ID_W-1:0] in_rs2,
  input  logic [REG_ID_W-1:0] in_rd,
  input  logic                in_use_rs1,
  input  logic                in_use_rs2,
  input  logic                in_has_rd,
  input  logic                rob_full,
  input  logic [ROB_ID_W-1:0] rob_tail,
  output logic                rob_alloc,
  output logic                is_call_rs1,
  output logic                is_call_rs2,
  output logic [REG_ID_W-1:0] call_rs1,
  output logic [REG_ID_W-1:0] call_rs2,
  output logic [ADDR_W-1:0]   decoder_call_pc,
  input  logic                rs1_busy,
  input  logic                rs2_busy,
  input  logic [DATA_W-1:0]   answer_rs1_data,
  input  logic [DATA_W-1:0]   answer_rs2_data,
  input  logic [ROB_ID_W-1:0] rs1_rob_id,
  input  logic [ROB_ID_W-1:0] rs2_rob_id,
  output logic                chg_dependency,
  output logic [REG_ID_W-1:0] chg_rs1,
  output logic [ROB_ID_W-1:0] dependent_rob_id,
  output logic [ADDR_W-1:0]   chg_pc,
  input  logic                is_commit,
  input  logic [ROB_ID_W-1:0] commit_rob_id,
  input  logic [DATA_W-1:0]   commit_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_pc,
  output logic [ROB_ID_W-1:0] out_rob_id,
  output logic [REG_ID_W-1:0] out_rd,
  output logic                out_q1_busy,
  output logic                out_q2_busy,
  output logic [DATA_W-1:0]   out_v1,
  output logic [DATA_W-1:0]   out_v2,
  output logic [ROB_ID_W-1:0] out_q1,
  output logic [ROB_ID_W-1:0] out_q2
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0]   pc_q;
  logic [REG_ID_W-1:0] rs1_q, rs2_q, rd_q;
  logic                use_rs1_q, use_rs2_q, has_rd_q;
  logic [ROB_ID_W-1:0] rob_id_q;
  logic                act, accept, in_read;

  assign act     = rdy && !rollback;
  assign in_read = (state_q == ST_READ);

  always_comb begin
    state_d        = state_q;
    in_ready       = 1'b0;
    rob_alloc      = 1'b0;
    chg_dependency = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = act && !rob_full;
        if (in_valid && in_ready) state_d = ST_READ;
      end
      ST_READ: begin
        state_d        = ST_SEND;
        rob_alloc      = act;
        chg_dependency = act && has_rd_q && (rd_q != '0);
      end
      ST_SEND: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rollback) state_d = ST_IDLE;
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      use_rs1_q <= 1'b0;
      use_rs2_q <= 1'b0;
      has_rd_q  <= 1'b0;
      rob_id_q  <= '0;
    end else begin
      if (accept) begin
        pc_q      <= in_pc;
        rs1_q     <= in_rs1;
        rs2_q     <= in_rs2;
        rd_q      <= in_rd;
        use_rs1_q <= in_use_rs1;
        use_rs2_q <= in_use_rs2;
        has_rd_q  <= in_has_rd;
      end
      if (rob_alloc) rob_id_q <= rob_tail;
    end
  end

  // Regfile query is combinational; answers are captured in the same READ cycle
  assign is_call_rs1      = rdy && in_read && use_rs1_q;
  assign is_call_rs2      = rdy && in_read && use_rs2_q;
  assign call_rs1         = rs1_q;
  assign call_rs2         = rs2_q;
  assign decoder_call_pc  = pc_q;
  assign chg_rs1          = rd_q;
  assign chg_pc           = pc_q;
  assign dependent_rob_id = chg_dependency ? rob_tail : '0;

  assign out_valid  = (state_q == ST_SEND);
  assign out_pc     = pc_q;
  assign out_rob_id = rob_id_q;
  assign out_rd     = rd_q;

  operand_slot #(.DATA_W(DATA_W), .REG_ID_W(REG_ID_W), .ROB_ID_W(ROB_ID_W)) u_slot1 (
    .clk          (clk),
    .rst          (rst),
    .en_i         (rdy),
    .capture_i    (in_read),
    .snoop_i      (in_read || out_valid),
    .use_i        (use_rs1_q),
    .idx_i        (rs1_q),
    .ans_busy_i   (rs1_busy),
    .ans_data_i   (answer_rs1_data),
    .ans_tag_i    (rs1_rob_id),
    .commit_i     (is_commit),
    .commit_id_i  (commit_rob_id),
    .commit_data_i(commit_data),
    .busy_o       (out_q1_busy),
    .data_o       (out_v1),
    .tag_o        (out_q1)
  );

  operand_slot #(.DATA_W(DATA_W), .REG_ID_W(REG_ID_W), .ROB_ID_W(ROB_ID_W)) u_slot2 (
    .clk          (clk),
    .rst          (rst),
    .en_i         (rdy),
    .capture_i    (in_read),
    .snoop_i      (in_read || out_valid),
    .use_i        (use_rs2_q),
    .idx_i        (rs2_q),
    .ans_busy_i   (rs2_busy),
    .ans_data_i   (answer_rs2_data),
    .ans_tag_i    (rs2_rob_id),
    .commit_i     (is_commit),
    .commit_id_i  (commit_rob_id),
    .commit_data_i(commit_data),
    .busy_o       (out_q2_busy),
    .data_o       (out_v2),
    .tag_o        (out_q2)
  );

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb/tb_dispatch_ctrl.sv - directed bench for dispatch_ctrl with packet scoreboard
module tb_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, in_valid, in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_has_rd;
  logic        rob_full, rob_alloc;
  logic [3:0]  rob_tail;
  logic        is_call_rs1, is_call_rs2;
  logic [4:0]  call_rs1, call_rs2;
  logic [31:0] decoder_call_pc;
  logic        rs1_busy, rs2_busy;
  logic [31:0] answer_rs1_data, answer_rs2_data;
  logic [3:0]  rs1_rob_id, rs2_rob_id;
  logic        chg_dependency;
  logic [4:0]  chg_rs1;
  logic [3:0]  dependent_rob_id;
  logic [31:0] chg_pc;
  logic        is_commit;
  logic [3:0]  commit_rob_id;
  logic [31:0] commit_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [3:0]  out_rob_id;
  logic [4:0]  out_rd;
  logic        out_q1_busy, out_q2_busy;
  logic [31:0] out_v1, out_v2;
  logic [3:0]  out_q1, out_q2;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  rob;
    logic [4:0]  rd;
    logic        q1b;
    logic        q2b;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  q1;
    logic [3:0]  q2;
  } pkt_t;

  pkt_t sb[$];
  pkt_t exp_p;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dispatch_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_has_rd(in_has_rd),
    .rob_full(rob_full), .rob_tail(rob_tail), .rob_alloc(rob_alloc),
    .is_call_rs1(is_call_rs1), .is_call_rs2(is_call_rs2),
    .call_rs1(call_rs1), .call_rs2(call_rs2), .decoder_call_pc(decoder_call_pc),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .answer_rs1_data(answer_rs1_data), .answer_rs2_data(answer_rs2_data),
    .rs1_rob_id(rs1_rob_id), .rs2_rob_id(rs2_rob_id),
    .chg_dependency(chg_dependency), .chg_rs1(chg_rs1),
    .dependent_rob_id(dependent_rob_id), .chg_pc(chg_pc),
    .is_commit(is_commit), .commit_rob_id(commit_rob_id), .commit_data(commit_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rob_id(out_rob_id), .out_rd(out_rd),
    .out_q1_busy(out_q1_busy), .out_q2_busy(out_q2_busy),
    .out_v1(out_v1), .out_v2(out_v2), .out_q1(out_q1), .out_q2(out_q2)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rf(input logic b1, input logic [31:0] d1, input logic [3:0] t1,
                        input logic b2, input logic [31:0] d2, input logic [3:0] t2);
    rs1_busy = b1; answer_rs1_data = d1; rs1_rob_id = t1;
    rs2_busy = b2; answer_rs2_data = d2; rs2_rob_id = t2;
  endtask

  // Present an instruction and return one tick after the accepting edge (READ cycle)
  task automatic issue(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic hr, input logic [3:0] tail);
    bit ok = 0;
    in_pc = pc; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
    in_use_rs1 = u1; in_use_rs2 = u2; in_has_rd = hr; rob_tail = tail;
    in_valid = 1'b1;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      step();
    end
    in_valid = 1'b0;
    chk("accept", {127'd0, ok}, 128'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && rdy && !rollback && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pkt", 128'd1, 128'd0);
      end else begin
        exp_p = sb.pop_front();
        chk("sb_pkt", {14'd0, out_pc, out_rob_id, out_rd, out_q1_busy, out_q2_busy,
                       out_v1, out_v2, out_q1, out_q2}, {14'd0, exp_p});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0;
    in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_has_rd = 1'b0;
    rob_full = 1'b0; rob_tail = '0; out_ready = 1'b0;
    is_commit = 1'b0; commit_rob_id = '0; commit_data = '0;
    set_rf(0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_pulses", {124'd0, rob_alloc, chg_dependency, is_call_rs1, is_call_rs2}, 128'd0);
    chk("rst_data", {out_pc, out_v1, out_v2, 20'd0, out_rob_id, out_q1, out_q2}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    step();

    // basic non-busy operands
    set_rf(0, 32'h11, 0, 0, 32'h22, 0);
    exp_p = '{pc: 32'h100, rob: 4'd2, rd: 5'd5, q1b: 1'b0, q2b: 1'b0,
              v1: 32'h11, v2: 32'h22, q1: 4'd0, q2: 4'd0};
    sb.push_back(exp_p);
    issue(32'h100, 5'd3, 5'd4, 5'd5, 1, 1, 1, 4'd2);
    @(negedge clk);
    chk("t1_alloc_chg", {126'd0, rob_alloc, chg_dependency}, 128'd3);
    chk("t1_rename", {119'd0, chg_rs1, dependent_rob_id}, {119'd0, 5'd5, 4'd2});
    chk("t1_query", {116'd0, is_call_rs1, is_call_rs2, call_rs1, call_rs2},
        {116'd0, 2'b11, 5'd3, 5'd4});
    chk("t1_pcs", {64'd0, decoder_call_pc, chg_pc}, {64'd0, 32'h100, 32'h100});
    chk("t1_in_ready_busy", {127'd0, in_ready}, 128'd0);
    step();
    @(negedge clk);
    chk("t1_out_valid", {127'd0, out_valid}, 128'd1);
    chk("t1_no_pulse_send", {126'd0, rob_alloc, chg_dependency}, 128'd0);
    step();
    drain();

    // busy rs1 resolved by a commit while stalled
    set_rf(1, 32'h55, 4'd7, 1, 32'h66, 4'd9);
    exp_p = '{pc: 32'h200, rob: 4'd3, rd: 5'd10, q1b: 1'b0, q2b: 1'b1,
              v1: 32'hDEAD, v2: 32'h66, q1: 4'd0, q2: 4'd9};
    sb.push_back(exp_p);
    issue(32'h200, 5'd6, 5'd8, 5'd10, 1, 1, 1, 4'd3);
    step();
    @(negedge clk);
    chk("t2_q1_busy_pre", {123'd0, out_q1_busy, out_q1}, {123'd0, 1'b1, 4'd7});
    step();
    is_commit = 1'b1; commit_rob_id = 4'd7; commit_data = 32'hDEAD;
    @(negedge clk);
    chk("t2_q1_busy_same", {127'd0, out_q1_busy}, 128'd1);
    step();
    is_commit = 1'b0;
    @(negedge clk);
    chk("t2_q1_resolved", {91'd0, out_q1_busy, out_v1, out_q1}, {91'd0, 1'b0, 32'hDEAD, 4'd0});
    chk("t2_q2_kept", {123'd0, out_q2_busy, out_q2}, {123'd0, 1'b1, 4'd9});
    step();
    drain();

    // rob_full blocks acceptance
    rob_full = 1'b1; in_valid = 1'b1; in_pc = 32'h300;
    @(negedge clk);
    chk("t3_in_ready_full", {127'd0, in_ready}, 128'd0);
    step();
    @(negedge clk);
    chk("t3_no_alloc_query", {125'd0, rob_alloc, is_call_rs1, is_call_rs2}, 128'd0);
    step();
    rob_full = 1'b0;
    set_rf(0, 32'h77, 0, 0, 32'h88, 0);
    exp_p = '{pc: 32'h300, rob: 4'd4, rd: 5'd2, q1b: 1'b0, q2b: 1'b0,
              v1: 32'h77, v2: 32'h88, q1: 4'd0, q2: 4'd0};
    sb.push_back(exp_p);
    issue(32'h300, 5'd1, 5'd9, 5'd2, 1, 1, 1, 4'd4);
    @(negedge clk);
    chk("t3_alloc_after", {127'd0, rob_alloc}, 128'd1);
    step();
    drain();

    // rollback during READ
    issue(32'h400, 5'd1, 5'd2, 5'd3, 1, 1, 1, 4'd5);
    rollback = 1'b1;
    @(negedge clk);
    chk("t4_no_pulses", {126'd0, rob_alloc, chg_dependency}, 128'd0);
    step();
    rollback = 1'b0;
    @(negedge clk);
    chk("t4_idle", {126'd0, out_valid, in_ready}, 128'd1);
    step();
    @(negedge clk);
    chk("t4_out_valid_low", {127'd0, out_valid}, 128'd0);
    step();

    // rd = 0 and unused rs2
    set_rf(0, 32'h1234, 0, 1, 32'h99, 4'd5);
    exp_p = '{pc: 32'h500, rob: 4'd6, rd: 5'd0, q1b: 1'b0, q2b: 1'b0,
              v1: 32'h1234, v2: 32'h0, q1: 4'd0, q2: 4'd0};
    sb.push_back(exp_p);
    issue(32'h500, 5'd12, 5'd13, 5'd0, 1, 0, 1, 4'd6);
    @(negedge clk);
    chk("t5_alloc_nochg", {125'd0, rob_alloc, chg_dependency, is_call_rs2}, {125'd0, 3'b100});
    step();
    drain();

    // rdy low in READ and in SEND
    set_rf(1, 32'h3333, 4'd11, 0, 32'h42, 0);
    exp_p = '{pc: 32'h600, rob: 4'd8, rd: 5'd14, q1b: 1'b0, q2b: 1'b0,
              v1: 32'hBEEF, v2: 32'h42, q1: 4'd0, q2: 4'd0};
    sb.push_back(exp_p);
    issue(32'h600, 5'd13, 5'd7, 5'd14, 1, 1, 1, 4'd8);
    rdy = 1'b0;
    @(negedge clk);
    chk("t6_read_frozen", {125'd0, rob_alloc, chg_dependency, is_call_rs1}, 128'd0);
    step();
    rdy = 1'b1;
    @(negedge clk);
    chk("t6_read_resumed", {126'd0, rob_alloc, chg_dependency}, 128'd3);
    step();
    rdy = 1'b0; out_ready = 1'b1;
    is_commit = 1'b1; commit_rob_id = 4'd11; commit_data = 32'hBEEF;
    @(negedge clk);
    chk("t6_send_frozen", {124'd0, out_valid, rob_alloc, is_call_rs1, out_q1_busy},
        {124'd0, 4'b1001});
    step();
    @(negedge clk);
    chk("t6_operand_held", {91'd0, out_q1_busy, out_v1, out_q1}, {91'd0, 1'b1, 32'h3333, 4'd11});
    step();
    rdy = 1'b1; is_commit = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("t6_state_held", {126'd0, out_valid, out_q1_busy}, 128'd3);
    step();
    is_commit = 1'b1;
    step();
    is_commit = 1'b0;
    @(negedge clk);
    chk("t6_resolved", {95'd0, out_q1_busy, out_v1}, {95'd0, 1'b0, 32'hBEEF});
    step();
    drain();

    step(); step();
    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_ctrl.md
# dispatch_ctrl

Dispatch-stage sequencer between the decoder and the register file / ROB. Accepts one decoded instruction at a time over a valid/ready handshake, looks up its source operands in the register file and allocates the ROB tail entry. It then renames the destination register by driving the regfile dependency-update port, and holds the resulting operand packet for the reservation station. While the packet is held, it snoops ROB commits so that operand tags resolved in the meantime are not lost. Rollback flushes it in one cycle.

## Interface
Parameters:
- DATA_W, 32, operand/data width
- ADDR_W, 32, PC width
- REG_ID_W, 5, architectural register index width
- ROB_ID_W, 4, ROB tag width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low all state freezes and no pulse outputs assert
- rollback  in  1  misprediction flush
- in_valid  in  1  decoder has instruction
- in_ready  out  1  controller can accept
- in_pc  in  ADDR_W  instruction PC
- in_rs1, in_rs2, in_rd  in  REG_ID_W  register indices
- in_use_rs1, in_use_rs2, in_has_rd  in  1  operand/destination present
- rob_full  in  1  ROB cannot allocate
- rob_tail  in  ROB_ID_W  tag of next ROB entry
- rob_alloc  out  1  one-cycle pulse: ROB takes tail entry
- is_call_rs1, is_call_rs2  out  1  regfile query strobes
- call_rs1, call_rs2  out  REG_ID_W  regfile query indices
- decoder_call_pc  out  ADDR_W  PC of queried instruction
- rs1_busy, rs2_busy  in  1  regfile answer: operand pending
- answer_rs1_data, answer_rs2_data  in  DATA_W  regfile answer data
- rs1_rob_id, rs2_rob_id  in  ROB_ID_W  regfile answer tag
- chg_dependency  out  1  one-cycle pulse: rename rd
- chg_rs1  out  REG_ID_W  register being renamed (= rd)
- dependent_rob_id  out  ROB_ID_W  new producer tag
- chg_pc  out  ADDR_W  PC of renaming instruction
- is_commit  in  1  ROB commit this cycle
- commit_rob_id  in  ROB_ID_W  committing tag
- commit_data  in  DATA_W  committed value
- out_valid  out  1  packet valid to RS
- out_ready  in  1  RS accepts
- out_pc  out  ADDR_W; out_rob_id  out  ROB_ID_W; out_rd  out  REG_ID_W
- out_q1_busy, out_q2_busy  out  1; out_v1, out_v2  out  DATA_W; out_q1, out_q2  out  ROB_ID_W

## Operation
- FSM states: IDLE, READ, SEND.
- IDLE: in_ready = !rob_full. On in_valid && in_ready, latch the instruction fields and go to READ.
- READ, for one cycle:
  - Drive is_call_rsX = in_use_rsX, call_rsX = latched indices, decoder_call_pc = latched PC.
  - Capture the answers. An unused operand, or index 0, is captured as busy=0, data=0, tag=0.
  - Pulse rob_alloc and latch rob_tail as out_rob_id.
  - If has_rd && rd!=0, pulse chg_dependency with chg_rs1=rd, dependent_rob_id=rob_tail, chg_pc=PC.
  - Go to SEND.
- SEND: out_valid=1. On out_ready, go to IDLE.
- Commit snoop: active in READ (after capture) and in SEND. If is_commit && qX_busy && commit_rob_id==qX, then in the same edge qX_busy←0, vX←commit_data, qX←0.
- Snoop while out_valid is high is permitted. The RS samples on the handshake edge, so the packet may improve while stalled.
- rollback (with rdy) in any state: state←IDLE, out_valid←0. No rob_alloc or chg_dependency is asserted that cycle, even in READ. Rollback takes priority over a same-cycle handshake.
- rdy low: the FSM and all registers hold; rob_alloc, chg_dependency and is_call_rsX are forced low.

## Timing
- Reset values: state IDLE; out_valid 0; rob_alloc, chg_dependency and is_call_rsX all 0; every data, tag and index output 0.
- Latency:
  - Accept at edge T.
  - READ during cycle T+1.
  - out_valid high from T+2.
  - With out_ready tied high, the next accept is possible at T+3, giving a throughput of one instruction per 3 cycles.
- The regfile answer is combinational, so the query and capture happen in the same READ cycle. The regfile already forwards a same-cycle commit.
- The regfile applies chg_dependency at the end of READ, so the next instruction's READ (≥2 cycles later) sees the new tag.
- An instruction whose rd equals its own rs1 reads the old mapping, because the query precedes the rename edge.
- rob_full rising after acceptance does not cancel the READ. The ROB guarantees rob_tail stays valid for the cycle after rob_full was sampled low.

## Structure
- Shared constants package, extending const.v: DATA_WID, ADDR_WID, REG_ID_WID, ROB_ID_WID, and the FSM state encodings.
- Sub-module `operand_slot`, instantiated twice. It holds busy/value/tag for one operand and implements the capture and commit-snoop logic.

## Test plan
- Reset, then in_valid with rs1=3 and rs2=4, both non-busy (data 0x11, 0x22), rd=5, rob_tail=2.
  - READ cycle: chg_dependency=1, chg_rs1=5, dependent_rob_id=2, rob_alloc=1.
  - T+2: out_valid with v1=0x11, v2=0x22, q*_busy=0, out_rob_id=2.
- rs1 busy with tag 7, out_ready=0 for 3 cycles; is_commit with commit_rob_id=7, data=0xDEAD in the 2nd SEND cycle.
  - Required: out_q1_busy=0, out_v1=0xDEAD from the next cycle.
  - out_q2 is unaffected.
- rob_full=1 with in_valid=1.
  - Required: in_ready=0, no rob_alloc, no query.
  - rob_full drops → accept on the next edge.
- rollback asserted during READ.
  - Required: chg_dependency=0, rob_alloc=0, IDLE next cycle, out_valid stays 0.
- rd=0 with in_has_rd=1.
  - Required: rob_alloc pulses, chg_dependency stays 0.
  - in_use_rs2=0 gives q2_busy=0 and v2=0.
- rdy low for 2 cycles in SEND, with is_commit matching a busy tag.
  - Required: state and operands unchanged, no pulses.
  - Resumes correctly after rdy returns.
